online_div_sequencer: RTL and testbench

- Cycle sequencer for the online (digit-serial, MSD-first) divider's V-value datapath.
- Generates the per-step STATE code, cnt_master, cnt_master_dis and computation_cycle that drive the V-value logic's carry-feedback, carry-propagate and borrow control.
- Runs the start/busy/done handshake with the operand source and stalls the datapath when no input digit is valid.

---
 rtl/div_pkg.sv | 21 ++
 rtl/div_step_counter.sv | 31 +++
 rtl/online_div_sequencer.sv | 139 +++++++++++++
 tb/tb_online_div_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the online divider.
// State codes are also decoded by the V-value logic.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ZERO = 2'b10;
  localparam logic [1:0] ST_FEED = 2'b01;
  localparam logic [1:0] ST_PROP = 2'b11;

  localparam int DELTA_DEF = 4;
  localparam int GROUP_DEF = 4;
  localparam int CNT_W     = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_DRAIN
  } seq_state_e;

endpackage

// File: rtl/div_step_counter.sv
// Saturating step counter with a one-step lagged copy.
// Clear wins over enable; the count sticks at all-ones.
module div_step_counter
  import div_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_dis
);

  // count steps; lagged copy takes the pre-step value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cnt_dis <= '0;
    end else if (clr) begin
      cnt     <= '0;
      cnt_dis <= '0;
    end else if (en) begin
      cnt_dis <= cnt;
      if (cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/online_div_sequencer.sv
// Step sequencer for the online divider V-value path.
// Zero rows, iteration digits, then one carry-flush step.
module online_div_sequencer
  import div_pkg::*;
#(
  parameter int DELTA  = DELTA_DEF,
  parameter int GROUP  = GROUP_DEF,
  parameter int MAXD_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MAXD_W-1:0] num_digits,
  input  logic              abort,
  input  logic              x_valid,
  output logic              x_ready,
  output logic              step_en,
  output logic [1:0]        state_code,
  output logic [CNT_W-1:0]  cnt_master,
  output logic [CNT_W-1:0]  cnt_master_dis,
  output logic [MAXD_W-1:0] computation_cycle,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] INIT_LAST =
    CNT_W'(DELTA - 1);
  localparam logic [CNT_W-1:0] GMASK =
    CNT_W'(GROUP - 1);

  seq_state_e        state_q;
  seq_state_e        state_d;
  logic [MAXD_W-1:0] nd_q;
  logic [MAXD_W-1:0] cc_q;
  logic              done_q;
  logic              done_d;
  logic              accept;
  logic              clr;
  logic              cc_inc;
  logic              last_digit;
  logic              prop;

  assign last_digit =
    (cc_q + MAXD_W'(1)) == nd_q;
  assign prop =
    (cnt_master & GMASK) == GMASK;

  // next state and step controls
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    clr        = 1'b0;
    cc_inc     = 1'b0;
    x_ready    = 1'b0;
    step_en    = 1'b0;
    state_code = ST_IDLE;
    busy       = 1'b1;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          accept  = 1'b1;
          clr     = 1'b1;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        x_ready    = 1'b1;
        step_en    = x_valid;
        state_code = ST_ZERO;
        if (x_valid && cnt_master == INIT_LAST)
          state_d = (nd_q == '0) ? S_DRAIN
                                 : S_ITER;
      end
      S_ITER: begin
        x_ready    = 1'b1;
        step_en    = x_valid;
        cc_inc     = x_valid;
        state_code = prop ? ST_PROP : ST_FEED;
        if (x_valid && last_digit)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        step_en    = 1'b1;
        state_code = ST_PROP;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      clr     = 1'b1;
      cc_inc  = 1'b0;
      done_d  = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // digit count, consumed digits and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nd_q   <= '0;
      cc_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (accept)
        nd_q <= num_digits;
      if (clr)
        cc_q <= '0;
      else if (cc_inc)
        cc_q <= cc_q + MAXD_W'(1);
    end
  end

  assign done              = done_q;
  assign computation_cycle = cc_q;

  div_step_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .en      (step_en),
    .cnt     (cnt_master),
    .cnt_dis (cnt_master_dis)
  );

endmodule

// File: tb/tb_online_div_sequencer.sv
// Scoreboard bench for online_div_sequencer.
// Stimulus queues expected steps; a monitor checks them.
module tb_online_div_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       x_valid = 1'b0;
  logic [6:0] num_digits = '0;
  logic       x_ready;
  logic       step_en;
  logic [1:0] state_code;
  logic [8:0] cnt_master;
  logic [8:0] cnt_master_dis;
  logic [6:0] computation_cycle;
  logic       busy;
  logic       done;

  online_div_sequencer #(
    .DELTA  (4),
    .GROUP  (4),
    .MAXD_W (7)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .num_digits        (num_digits),
    .abort             (abort),
    .x_valid           (x_valid),
    .x_ready           (x_ready),
    .step_en           (step_en),
    .state_code        (state_code),
    .cnt_master        (cnt_master),
    .cnt_master_dis    (cnt_master_dis),
    .computation_cycle (computation_cycle),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit         is_done;
    bit         drain;
    logic [1:0] code;
    logic [8:0] cnt;
    logic [8:0] dis;
    logic [6:0] cc;
    int         t;
  } exp_t;

  exp_t sb[$];
  exp_t r;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void push_step(bit dr,
                                    logic [1:0] code,
                                    int c, int cc);
    exp_t e;
    e.is_done = 1'b0;
    e.drain   = dr;
    e.code    = code;
    e.cnt     = 9'(c);
    e.dis     = (c == 0) ? 9'd0 : 9'(c - 1);
    e.cc      = 7'(cc);
    e.t       = 0;
    sb.push_back(e);
  endfunction

  // DELTA=4 zero rows, nd digits, one drain, then done.
  // stop_at >= 0 cuts the run after that cnt_master step.
  function automatic void push_run(int nd, int stalls,
                                   int stop_at);
    exp_t e;
    int   c;
    for (int k = 0; k < 4; k++) begin
      if (stop_at >= 0 && k > stop_at) return;
      push_step(1'b0, 2'b10, k, 0);
    end
    for (int i = 0; i < nd; i++) begin
      c = 4 + i;
      if (stop_at >= 0 && c > stop_at) return;
      push_step(1'b0,
                (c % 4 == 3) ? 2'b11 : 2'b01,
                c, i);
    end
    c = 4 + nd;
    if (stop_at >= 0 && c > stop_at) return;
    push_step(1'b1, 2'b11, c, nd);
    e.is_done = 1'b1;
    e.drain   = 1'b0;
    e.code    = 2'b00;
    e.cnt     = 9'(5 + nd);
    e.dis     = '0;
    e.cc      = 7'(nd);
    e.t       = cyc + 4 + nd + 2 + stalls;
    sb.push_back(e);
  endfunction

  // monitor: every step or done must match the queue head
  always @(negedge clk) begin
    if (rst_n && (step_en || done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_out",
            {30'd0, step_en, done}, 32'd0);
      end else begin
        r = sb.pop_front();
        if (r.is_done) begin
          chk("done", done, 1);
          chk("done_cyc", cyc, r.t);
          chk("done_cnt", cnt_master, r.cnt);
          chk("done_cc", computation_cycle, r.cc);
          chk("done_busy", busy, 0);
        end else begin
          chk("step_nodone", done, 0);
          chk("code", state_code, r.code);
          chk("cnt", cnt_master, r.cnt);
          chk("dis", cnt_master_dis, r.dis);
          chk("cc", computation_cycle, r.cc);
          chk("x_ready", x_ready, r.drain ? 0 : 1);
        end
      end
    end
  end

  task automatic pulse_start(input int nd);
    num_digits = 7'(nd);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input int v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (cnt_master == 9'(v)) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_cnt", ok, 1);
  endtask

  task automatic chk_zero(input string name);
    chk(name,
        {6'd0, x_ready, step_en, state_code,
         cnt_master, cnt_master_dis,
         computation_cycle, busy, done},
        32'd0);
  endtask

  initial begin
    #3;
    chk_zero("reset_outs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    x_valid = 1'b1;
    @(negedge clk);
    chk_zero("idle_outs");
    @(posedge clk); #1;

    // abort together with start in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", busy, 0);
    chk("abort_start_code", state_code, 0);
    @(posedge clk); #1;

    // basic run
    push_run(8, 0, -1);
    pulse_start(8);
    chk("busy_after_start", busy, 1);
    wait_empty("basic_wait");

    // stall of 3 cycles at cnt_master=6
    push_run(8, 3, -1);
    pulse_start(8);
    wait_cnt(6);
    x_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_step_en", step_en, 0);
      chk("stall_cnt", cnt_master, 6);
      chk("stall_dis", cnt_master_dis, 5);
      chk("stall_cc", computation_cycle, 2);
      chk("stall_code", state_code, 2'b01);
      @(posedge clk);
    end
    #1;
    x_valid = 1'b1;
    wait_empty("stall_wait");

    // zero digits
    push_run(0, 0, -1);
    pulse_start(0);
    wait_empty("zero_wait");

    // abort at cnt_master=9
    push_run(8, 0, 9);
    pulse_start(8);
    wait_cnt(9);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk_zero("abort_outs");
    repeat (20) @(posedge clk);
    #1;
    chk("abort_sb", sb.size(), 0);

    // second start while busy is ignored
    push_run(8, 0, -1);
    pulse_start(8);
    wait_cnt(5);
    num_digits = 7'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_digits = 7'd0;
    wait_empty("ignore_wait");

    // asynchronous reset mid-ITER
    push_run(8, 0, 6);
    pulse_start(8);
    wait_cnt(6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    @(posedge clk); #1;
    chk_zero("rst_held");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("final_sb", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
